// File: rtl/tcm_arbiter.sv
// Shares the TCM between ibus and dbus; dbus has priority, ibus gets a grant after at most MAX_D_STREAK dbus wins.
// Requests pass through combinationally, resp one cycle later; a losing master holds req until it sees gnt.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tcm_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic                      i_w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
  input  logic                      i_req,
  output logic                      i_gnt,
  output logic [`BUS_WIDTH-1:0]     i_rdata,
  output logic                      i_resp,
  output logic                      i_fault,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic                      d_w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] d_acc,
  input  logic [`BUS_WIDTH-1:0]     d_wdata,
  input  logic                      d_req,
  output logic                      d_gnt,
  output logic [`BUS_WIDTH-1:0]     d_rdata,
  output logic                      d_resp,
  output logic                      d_fault,
  output logic [ADDR_WIDTH-1:0]     t_addr,
  output logic                      t_w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] t_acc,
  output logic [`BUS_WIDTH-1:0]     t_wdata,
  output logic                      t_req,
  input  logic [`BUS_WIDTH-1:0]     t_rdata,
  input  logic                      t_resp,
  input  logic                      t_fault
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  logic [3:0] streak;
  logic       owner_v;
  owner_e     owner_id;
  logic       i_win;
  logic       d_win;
  logic       i_wr_fault;

  always_comb begin
    i_win      = i_req & (~d_req | (streak == STREAK_MAX));
    d_win      = d_req & ~i_win;
    i_wr_fault = i_win & i_w_rb;
    // ibus writes are refused here and never reach the TCM
    t_req      = d_win | (i_win & ~i_w_rb);
    t_addr     = d_addr;
    t_w_rb     = d_w_rb;
    t_acc      = d_acc;
    t_wdata    = d_wdata;
    if (i_win) begin
      t_addr  = i_addr;
      t_w_rb  = i_w_rb;
      t_acc   = i_acc;
      t_wdata = '0;
    end
  end

  assign i_gnt   = i_win;
  assign d_gnt   = d_win;
  assign i_fault = i_wr_fault | (i_win & t_req & t_fault);
  assign d_fault = d_win & t_fault;

  // rstn gates delivery so a transaction accepted just before reset is dropped
  assign i_resp  = rstn & t_resp & owner_v & (owner_id == OWN_I);
  assign d_resp  = rstn & t_resp & owner_v & (owner_id == OWN_D);
  assign i_rdata = t_rdata;
  assign d_rdata = t_rdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      streak   <= '0;
      owner_v  <= 1'b0;
      owner_id <= OWN_I;
    end else begin
      owner_v  <= t_req & ~t_fault;
      owner_id <= d_win ? OWN_D : OWN_I;
      if (d_win & i_req) begin
        if (streak != STREAK_MAX) streak <= streak + 4'd1;
      end else if (i_win | d_win) begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Self-checking bench for tcm_arbiter: scenario tasks check grants/faults inline, a scoreboard queue checks responses.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tb_tcm_arbiter;
  localparam int AW   = 14;
  localparam int MAXS = 4;
  localparam int BW   = `BUS_WIDTH;
  localparam int CW   = `BUS_ACC_WIDTH;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_w_rb = 1'b0;
  logic [CW-1:0] i_acc = '0;
  logic          i_req = 1'b0;
  logic          i_gnt, i_resp, i_fault;
  logic [BW-1:0] i_rdata;
  logic [AW-1:0] d_addr = '0;
  logic          d_w_rb = 1'b0;
  logic [CW-1:0] d_acc = '0;
  logic [BW-1:0] d_wdata = '0;
  logic          d_req = 1'b0;
  logic          d_gnt, d_resp, d_fault;
  logic [BW-1:0] d_rdata;
  logic [AW-1:0] t_addr;
  logic          t_w_rb;
  logic [CW-1:0] t_acc;
  logic [BW-1:0] t_wdata;
  logic          t_req;
  logic [BW-1:0] t_rdata = '0;
  logic          t_resp = 1'b0;
  logic          t_fault;

  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_addr = 14'h0002;
  logic          wr_vld = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;

  int errors = 0;
  int checks = 0;
  int m_streak = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned   cyc;
    bit            is_d;
    bit            chk;
    logic [BW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  tcm_arbiter #(.ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rstn(rstn),
    .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_req(i_req),
    .i_gnt(i_gnt), .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
    .t_addr(t_addr), .t_w_rb(t_w_rb), .t_acc(t_acc), .t_wdata(t_wdata), .t_req(t_req),
    .t_rdata(t_rdata), .t_resp(t_resp), .t_fault(t_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] dflt(input logic [AW-1:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  // TCM model: faults combinationally on fault_addr, answers one cycle after an accepted request (ignores rstn)
  assign t_fault = fault_en & t_req & (t_addr == fault_addr);

  always @(posedge clk) begin
    t_resp <= t_req & ~t_fault;
    if (t_req & ~t_fault) begin
      if (t_w_rb) begin
        wr_vld  <= 1'b1;
        wr_addr <= t_addr;
        wr_data <= t_wdata;
      end else begin
        t_rdata <= (wr_vld && wr_addr == t_addr) ? wr_data : dflt(t_addr);
      end
    end
  end

  // Scoreboard: each entry names the cycle in which exactly one response is due
  always @(negedge clk) begin : mon
    exp_t e;
    logic [BW-1:0] got;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL resp_stale: entry for cycle %0d still queued at cycle %0d", e.cyc, cyc);
    end
    checks++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (i_resp !== !e.is_d || d_resp !== e.is_d) begin
        errors++;
        $display("FAIL resp_route cyc=%0d: i_resp=%b d_resp=%b, expected i_resp=%b d_resp=%b",
                 cyc, i_resp, d_resp, !e.is_d, e.is_d);
      end else if (e.chk) begin
        got = e.is_d ? d_rdata : i_rdata;
        checks++;
        if (got !== e.data) begin
          errors++;
          $display("FAIL resp_rdata cyc=%0d: got %h, expected %h", cyc, got, e.data);
        end
      end
    end else if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL resp_spurious cyc=%0d: i_resp=%b d_resp=%b, expected 0 0", cyc, i_resp, d_resp);
    end
  end

  task automatic push_exp(input bit is_d, input bit chk, input logic [BW-1:0] data);
    exp_t e;
    e.cyc = cyc + 1; e.is_d = is_d; e.chk = chk; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0; i_w_rb = 1'b0; d_w_rb = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || t_req !== 1'b0 || i_fault !== 1'b0 || d_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b%b t_req=%b fault=%b%b, expected all 0", i_gnt, d_gnt, t_req, i_fault, d_fault);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    m_streak = 0;
    @(negedge clk);
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: i_resp=%b d_resp=%b, expected 0 0", i_resp, d_resp);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_both(input int n, input logic [AW-1:0] ia, input logic [AW-1:0] da);
    bit exp_i;
    logic [AW-1:0] ea;
    logic [BW-1:0] ew;
    for (int k = 0; k < n; k++) begin
      i_req = 1'b1; i_w_rb = 1'b0; i_addr = ia; i_acc = 2'b10;
      d_req = 1'b1; d_w_rb = 1'b0; d_addr = da; d_acc = 2'b10; d_wdata = 32'h1234_5678;
      @(negedge clk);
      exp_i = (m_streak == MAXS);
      ea = exp_i ? ia : da;
      ew = exp_i ? '0 : 32'h1234_5678;
      checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
        errors++;
        $display("FAIL both_gnt k=%0d: i_gnt=%b d_gnt=%b, expected %b %b", k, i_gnt, d_gnt, exp_i, !exp_i);
      end
      checks++;
      if (t_req !== 1'b1 || t_addr !== ea || t_wdata !== ew) begin
        errors++;
        $display("FAIL both_mux k=%0d: t_req=%b t_addr=%h t_wdata=%h, expected 1 %h %h", k, t_req, t_addr, t_wdata, ea, ew);
      end
      push_exp(!exp_i, 1'b1, dflt(ea));
      m_streak = exp_i ? 0 : ((m_streak == MAXS) ? MAXS : m_streak + 1);
      @(posedge clk); #1;
    end
    idle(0);
  endtask

  task automatic test_streak();
    run_both(20, 14'h0104, 14'h0200);
    idle(2);
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_w_rb = 1'b0; i_addr = 14'h0010; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || t_req !== 1'b1 || t_addr !== 14'h0010) begin
      errors++;
      $display("FAIL b2b_iread: i_gnt=%b d_gnt=%b t_req=%b t_addr=%h, expected 1 0 1 0010", i_gnt, d_gnt, t_req, t_addr);
    end
    push_exp(1'b0, 1'b1, dflt(14'h0010));
    m_streak = 0;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b1; d_w_rb = 1'b1; d_addr = 14'h0020; d_acc = 2'b10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || t_req !== 1'b1 || t_w_rb !== 1'b1 || t_wdata !== 32'hDEADBEEF || t_addr !== 14'h0020) begin
      errors++;
      $display("FAIL b2b_dwrite: d_gnt=%b t_req=%b t_w_rb=%b t_wdata=%h t_addr=%h, expected 1 1 1 deadbeef 0020",
               d_gnt, t_req, t_w_rb, t_wdata, t_addr);
    end
    push_exp(1'b1, 1'b0, '0);
    @(posedge clk); #1;
    d_w_rb = 1'b0; d_wdata = '0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || t_req !== 1'b1 || t_w_rb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dread: d_gnt=%b t_req=%b t_w_rb=%b, expected 1 1 0", d_gnt, t_req, t_w_rb);
    end
    push_exp(1'b1, 1'b1, 32'hDEADBEEF);
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_ibus_write();
    run_both(2, 14'h0104, 14'h0200);
    i_req = 1'b1; i_w_rb = 1'b1; i_addr = 14'h0050; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || i_fault !== 1'b1 || t_req !== 1'b0 || d_fault !== 1'b0) begin
      errors++;
      $display("FAIL ibus_write: i_gnt=%b i_fault=%b t_req=%b d_fault=%b, expected 1 1 0 0", i_gnt, i_fault, t_req, d_fault);
    end
    m_streak = 0;
    @(posedge clk); #1;
    run_both(5, 14'h0104, 14'h0200);
    idle(2);
  endtask

  task automatic test_tcm_fault();
    i_req = 1'b1; i_w_rb = 1'b0; i_addr = 14'h0030; d_req = 1'b0;
    @(negedge clk);
    push_exp(1'b0, 1'b1, dflt(14'h0030));
    m_streak = 0;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b1; d_w_rb = 1'b0; d_addr = 14'h0002; d_acc = 2'b10; fault_en = 1'b1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || d_fault !== 1'b1 || i_fault !== 1'b0) begin
      errors++;
      $display("FAIL tcm_fault: d_gnt=%b d_fault=%b i_fault=%b, expected 1 1 0", d_gnt, d_fault, i_fault);
    end
    @(posedge clk); #1;
    fault_en = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 14'h0040;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || i_fault !== 1'b0 || d_fault !== 1'b0 || t_req !== 1'b1) begin
      errors++;
      $display("FAIL fault_recover: i_gnt=%b i_fault=%b d_fault=%b t_req=%b, expected 1 0 0 1", i_gnt, i_fault, d_fault, t_req);
    end
    push_exp(1'b0, 1'b1, dflt(14'h0040));
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    run_both(2, 14'h0104, 14'h0200);
    i_req = 1'b1; i_addr = 14'h0104; d_req = 1'b1; d_w_rb = 1'b0; d_addr = 14'h0208;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rmid_accept: d_gnt=%b i_gnt=%b, expected 1 0", d_gnt, i_gnt);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (d_resp !== 1'b0 || t_resp !== 1'b1) begin
      errors++;
      $display("FAIL rmid_resp: d_resp=%b t_resp=%b, expected 0 1", d_resp, t_resp);
    end
    m_streak = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    run_both(6, 14'h0104, 14'h0200);
    idle(2);
  endtask

  task automatic test_ibus_only();
    for (int k = 0; k < 10; k++) begin
      i_req = 1'b1; i_w_rb = 1'b0; i_addr = 14'(14'h0100 + 4 * k); d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (i_gnt !== 1'b1 || t_addr !== i_addr) begin
        errors++;
        $display("FAIL ionly_gnt k=%0d: i_gnt=%b t_addr=%h, expected 1 %h", k, i_gnt, t_addr, i_addr);
      end
      push_exp(1'b0, 1'b1, dflt(i_addr));
      m_streak = 0;
      @(posedge clk); #1;
    end
    run_both(5, 14'h0104, 14'h0200);
    idle(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streak();
    test_back_to_back();
    test_ibus_write();
    test_tcm_fault();
    test_reset_mid();
    test_ibus_only();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses never arrived, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
